fetch_unit: RTL

Instruction-fetch stage of the 64-bit pipelined RISC-V core. It is the producer end of the IF/ID interface whose consumer is the decode stage.
- Owns the PC and drives instruction-memory reads.
- Registers fetched instructions into the IF/ID pipeline register.
- Honours stall requests from the hazard unit and flush/redirect requests from branch resolution.
- Detects end-of-program and halts fetch.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_unit.sv | 67 ++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the 64-bit pipelined RISC-V core.
// Covers the datapath width, the canonical NOP and the major opcodes used by decode.
package riscv_pkg;

  localparam int unsigned XLEN = 64;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_R      = 7'b0110011,
    OPC_I      = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and squash controls.
// Priority is reset, then squash, then hold, then load.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            squash,
  input  logic [31:0]     d_instr,
  input  logic [XLEN-1:0] d_pc,
  input  logic            d_valid,
  output logic [31:0]     q_instr,
  output logic [XLEN-1:0] q_pc,
  output logic            q_valid
);

  // Squash beats hold so that a wrong-path instruction is never kept.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || squash) begin
      q_instr <= INSTR_NOP;
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (!hold) begin
      q_instr <= d_instr;
      q_pc    <= d_pc;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and feeds IF/ID.
// Handles stall, flush/redirect and end-of-program halt.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     IMEM_DEPTH = 64,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_DEPTH) * XLEN'(4);

  logic [XLEN-1:0] pc;
  logic            end_of_prog;
  logic            fetch_ok;
  logic [31:0]     d_instr;

  assign imem_addr   = pc;
  assign end_of_prog = (imem_rdata == 32'h0) || (pc >= PC_LIMIT);
  assign fetch_ok    = !halted && !end_of_prog;
  assign d_instr     = fetch_ok ? imem_rdata : INSTR_NOP;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (flush) begin
      // Redirect also cancels a halt reached on the wrong path.
      pc     <= {branch_target[XLEN-1:2], 2'b00};
      halted <= 1'b0;
    end else if (!stall && !halted) begin
      if (end_of_prog) begin
        halted <= 1'b1;
      end else begin
        pc          <= pc + XLEN'(4);
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .hold    (stall),
    .squash  (flush),
    .d_instr (d_instr),
    .d_pc    (pc),
    .d_valid (fetch_ok),
    .q_instr (if_id_instr),
    .q_pc    (if_id_pc),
    .q_valid (if_id_valid)
  );

endmodule
